// File: rtl/i2s_tx_arbiter.sv
// Shares the I2S DAC sample port between NUM_SRC producers.
// One-deep output register, fixed/round-robin grant, underrun count.
module i2s_tx_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int DATA_WIDTH = 16,
    parameter int SRC_ID_W   = 2,
    parameter int UNDERRUN_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC-1:0]            src_enable,
    input  logic                          rr_mode,
    output logic [DATA_WIDTH-1:0]         dac_data_out,
    output logic                          dac_data_valid,
    input  logic                          dac_ready,
    output logic [SRC_ID_W-1:0]           dac_src_id,
    output logic [UNDERRUN_W-1:0]         underrun_cnt,
    input  logic                          underrun_clr
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state;
    logic [SRC_ID_W-1:0]   rr_ptr;
    logic [SRC_ID_W-1:0]   grant_id;
    logic [SRC_ID_W:0]     rr_idx;
    logic [NUM_SRC-1:0]    eligible;
    logic [DATA_WIDTH-1:0] src_arr [NUM_SRC];
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  grant_any;
    logic                  grant;
    logic                  consume;
    logic                  load_ok;
    logic                  dac_ready_q;
    logic                  underrun_evt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_arr[i]  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign eligible[i] = src_valid[i] && src_enable[i];
    end

    assign dac_data_valid = (state == FULL);
    assign consume        = dac_data_valid && dac_ready;
    assign load_ok        = !dac_data_valid || consume;
    assign grant          = !rst && load_ok && grant_any;

    // Scan downward so the last hit is the highest-priority candidate.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        rr_idx    = '0;
        if (rr_mode) begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                rr_idx = {1'b0, rr_ptr} + (SRC_ID_W+1)'(k);
                if (rr_idx >= (SRC_ID_W+1)'(NUM_SRC))
                    rr_idx = rr_idx - (SRC_ID_W+1)'(NUM_SRC);
                if (eligible[rr_idx[SRC_ID_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = rr_idx[SRC_ID_W-1:0];
                end
            end
        end else begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grant_any = 1'b1;
                    grant_id  = SRC_ID_W'(i);
                end
            end
        end
    end

    assign grant_data = src_arr[grant_id];

    always_comb begin
        src_ready = '0;
        if (grant)
            src_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            dac_data_out <= '0;
            dac_src_id   <= '0;
            rr_ptr       <= '0;
        end else begin
            unique case (state)
                EMPTY: if (grant) state <= FULL;
                FULL:  if (consume && !grant) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (grant) begin
                dac_data_out <= grant_data;
                dac_src_id   <= grant_id;
                rr_ptr       <= (grant_id == SRC_ID_W'(NUM_SRC - 1)) ?
                                '0 : grant_id + SRC_ID_W'(1);
            end
        end
    end

    // Starvation: the DAC asks for a sample while nothing is buffered.
    assign underrun_evt = dac_ready && !dac_ready_q && !dac_data_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_ready_q  <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            dac_ready_q <= dac_ready;
            if (underrun_clr)
                underrun_cnt <= '0;
            else if (underrun_evt && underrun_cnt != '1)
                underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
        end
    end

endmodule

// File: tb/tb_i2s_tx_arbiter.sv
// Directed bench for i2s_tx_arbiter.
// A second instance with a 2-bit underrun counter covers saturation.
module tb_i2s_tx_arbiter;

    localparam int NS = 3;
    localparam int DW = 16;
    localparam int IW = 2;

    logic           clk;
    logic           rst;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]  src_valid;
    logic [NS-1:0]  src_enable;
    logic           rr_mode;
    logic           dac_ready;
    logic           underrun_clr;

    logic [NS-1:0]  src_ready;
    logic [DW-1:0]  dac_data_out;
    logic           dac_data_valid;
    logic [IW-1:0]  dac_src_id;
    logic [15:0]    underrun_cnt;

    logic [NS-1:0]  s_src_ready;
    logic [DW-1:0]  s_dac_data_out;
    logic           s_dac_data_valid;
    logic [IW-1:0]  s_dac_src_id;
    logic [1:0]     s_underrun_cnt;

    int checks = 0;
    int errors = 0;

    i2s_tx_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .SRC_ID_W(IW), .UNDERRUN_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .src_enable(src_enable),
        .rr_mode(rr_mode),
        .dac_data_out(dac_data_out), .dac_data_valid(dac_data_valid),
        .dac_ready(dac_ready), .dac_src_id(dac_src_id),
        .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr)
    );

    i2s_tx_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .SRC_ID_W(IW), .UNDERRUN_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst),
        .src_data(src_data), .src_valid(src_valid),
        .src_ready(s_src_ready), .src_enable(src_enable),
        .rr_mode(rr_mode),
        .dac_data_out(s_dac_data_out), .dac_data_valid(s_dac_data_valid),
        .dac_ready(dac_ready), .dac_src_id(s_dac_src_id),
        .underrun_cnt(s_underrun_cnt), .underrun_clr(underrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [DW-1:0] v);
        src_data[i*DW +: DW] = v;
    endtask

    initial begin
        logic [1:0] rr_exp [6];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        rst          = 1'b1;
        src_data     = '0;
        src_valid    = '0;
        src_enable   = '1;
        rr_mode      = 1'b0;
        dac_ready    = 1'b0;
        underrun_clr = 1'b0;
        #2;
        check("rst_valid", 32'(dac_data_valid), 0);
        check("rst_data", 32'(dac_data_out), 0);
        check("rst_id", 32'(dac_src_id), 0);
        check("rst_cnt", 32'(underrun_cnt), 0);
        check("rst_ready", 32'(src_ready), 0);
        step();
        step();
        rst = 1'b0;

        // Fixed priority: src0 wins while valid.
        set_src(0, 16'h1111);
        set_src(1, 16'h2222);
        set_src(2, 16'h3333);
        src_valid = 3'b111;
        dac_ready = 1'b1;
        #1;
        check("fp_ready0", 32'(src_ready), 32'b001);
        for (int n = 0; n < 3; n++) begin
            step();
            check("fp_valid", 32'(dac_data_valid), 1);
            check("fp_data", 32'(dac_data_out), 32'h1111);
            check("fp_ready", 32'(src_ready), 32'b001);
        end
        src_valid = 3'b110;
        #1;
        check("fp_ready1", 32'(src_ready), 32'b010);
        step();
        check("fp_data1", 32'(dac_data_out), 32'h2222);
        check("fp_id1", 32'(dac_src_id), 1);

        // Park the pointer at 0 by granting src2 once.
        src_valid = 3'b100;
        step();
        check("park_id", 32'(dac_src_id), 2);
        src_valid = 3'b000;
        step();
        check("park_empty", 32'(dac_data_valid), 0);

        // Round-robin over three always-valid sources.
        rr_mode   = 1'b1;
        src_valid = 3'b111;
        #1;
        for (int n = 0; n < 6; n++) begin
            check("rr_ready", 32'(src_ready), 32'(1 << rr_exp[n]));
            check("rr_onehot", 32'($countones(src_ready)), 1);
            step();
            check("rr_id", 32'(dac_src_id), 32'(rr_exp[n]));
        end

        // Backpressure holds 0xABCD, then reloads with no bubble.
        src_valid = 3'b000;
        step();
        check("bp_empty", 32'(dac_data_valid), 0);
        set_src(1, 16'hABCD);
        set_src(0, 16'h5555);
        src_valid = 3'b010;
        dac_ready = 1'b0;
        step();
        src_valid = 3'b001;
        for (int n = 0; n < 20; n++) begin
            check("bp_data", 32'(dac_data_out), 32'hABCD);
            check("bp_valid", 32'(dac_data_valid), 1);
            check("bp_ready", 32'(src_ready), 0);
            step();
        end
        dac_ready = 1'b1;
        #1;
        check("bp_reload", 32'(src_ready), 32'b001);
        step();
        check("bp_data2", 32'(dac_data_out), 32'h5555);
        check("bp_valid2", 32'(dac_data_valid), 1);
        check("bp_id2", 32'(dac_src_id), 0);

        // Mask: disabled source is never granted.
        src_valid = 3'b000;
        step();
        rr_mode    = 1'b0;
        src_enable = 3'b101;
        set_src(1, 16'h2222);
        src_valid  = 3'b010;
        #1;
        check("mask_ready", 32'(src_ready), 0);
        step();
        check("mask_valid", 32'(dac_data_valid), 0);
        step();
        check("mask_valid2", 32'(dac_data_valid), 0);
        src_enable = 3'b111;
        #1;
        check("mask_ready1", 32'(src_ready), 32'b010);
        step();
        check("mask_data", 32'(dac_data_out), 32'h2222);
        check("mask_id", 32'(dac_src_id), 1);
        src_valid = 3'b000;
        step();
        check("mask_empty", 32'(dac_data_valid), 0);

        // Underrun counting, clear priority and saturation.
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("ur_clr", 32'(underrun_cnt), 0);
        check("ur_clr_sat", 32'(s_underrun_cnt), 0);
        for (int n = 0; n < 5; n++) begin
            dac_ready = 1'b0;
            step();
            dac_ready = 1'b1;
            step();
        end
        check("ur_cnt5", 32'(underrun_cnt), 5);
        check("ur_sat", 32'(s_underrun_cnt), 3);
        dac_ready = 1'b0;
        step();
        dac_ready    = 1'b1;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("ur_clr_edge", 32'(underrun_cnt), 0);
        check("ur_clr_edge_sat", 32'(s_underrun_cnt), 0);

        // Async reset while FULL and stalled.
        dac_ready = 1'b0;
        step();
        dac_ready = 1'b1;
        step();
        check("ar_cnt1", 32'(underrun_cnt), 1);
        dac_ready = 1'b0;
        rr_mode   = 1'b1;
        set_src(1, 16'hABCD);
        src_valid = 3'b010;
        step();
        check("ar_full", 32'(dac_data_valid), 1);
        check("ar_data", 32'(dac_data_out), 32'hABCD);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid0", 32'(dac_data_valid), 0);
        check("ar_data0", 32'(dac_data_out), 0);
        check("ar_cnt0", 32'(underrun_cnt), 0);
        check("ar_ready0", 32'(src_ready), 0);
        step();
        rst       = 1'b0;
        src_valid = 3'b111;
        dac_ready = 1'b1;
        #1;
        check("ar_rr_ready", 32'(src_ready), 32'b001);
        for (int n = 0; n < 3; n++) begin
            step();
            check("ar_rr_id", 32'(dac_src_id), 32'(rr_exp[n]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
